// File: rtl/stim_sched_pkg.sv
// stim_sched_pkg: shared state encoding and source-id width helper for stim_sched.
package stim_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, DONE = 2'b11} state_t;
  function automatic int sw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stim_rr_arb.sv
// stim_rr_arb: N-way requester pick; round-robin, or fixed priority when STIM_SCHED_STRICT_EN is defined.
module stim_rr_arb #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  elig_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] idx_o
);
`ifdef STIM_SCHED_STRICT_EN
  logic found;
  logic unused;
  assign unused = clk ^ reset ^ adv_i;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && elig_i[k]) begin
        found    = 1'b1;
        idx_o    = SW'(k);
        gnt_o[k] = 1'b1;
      end
    end
  end
`else
  logic [SW-1:0] ptr_q, ptr_d;
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && elig_i[(int'(ptr_q) + k) % N]) begin
        found                            = 1'b1;
        idx_o                            = SW'((int'(ptr_q) + k) % N);
        gnt_o[(int'(ptr_q) + k) % N]     = 1'b1;
      end
    end
    ptr_d = (adv_i && found) ? ((idx_o == SW'(N - 1)) ? '0 : idx_o + SW'(1)) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif
endmodule

// File: rtl/stim_sched.sv
// stim_sched: sequences N stimulus generators and merges their packets into one registered output slot.
// Build option: STIM_SCHED_STRICT_EN selects fixed-priority arbitration.
module stim_sched
  import stim_sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 64,
  parameter int SW   = sw_of(N),
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  output logic [N-1:0]    start,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_packet,
  input  logic [N-1:0]    in_done,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_packet,
  output logic [SW-1:0]   out_src,
  input  logic            out_ready,
  output logic            busy,
  output logic            all_done,
  output logic [CNTW-1:0] pkt_count
);
  state_t          state_q, state_d;
  logic [N-1:0]    done_q, done_d, elig, gnt;
  logic [SW-1:0]   idx, src_q, src_d;
  logic            ov_q, ov_d, load, enter;
  logic [DW-1:0]   pkt_q, pkt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // A requester stops competing once its done has been seen, but not in the cycle it arrives.
  assign elig  = in_valid & ~done_q;
  assign load  = (state_q == RUN) && (!ov_q || out_ready) && (|elig);
  assign enter = (state_q == IDLE) && go;

  stim_rr_arb #(.N(N), .SW(SW)) u_arb (
    .clk(clk), .reset(reset), .elig_i(elig), .adv_i(load), .gnt_o(gnt), .idx_o(idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? RUN : IDLE;
      RUN:     state_d = &(done_q | in_done) ? DRAIN : RUN;
      DRAIN:   state_d = (!ov_q || out_ready) ? DONE : DRAIN;
      default: state_d = go ? DONE : IDLE;
    endcase
    done_d = enter ? '0 : (state_q == RUN) ? (done_q | in_done) : done_q;
    ov_d   = load | (ov_q & ~out_ready);
    pkt_d  = load ? in_packet[int'(idx)*DW +: DW] : pkt_q;
    src_d  = load ? idx : src_q;
    cnt_d  = enter ? '0 : (ov_q && out_ready && !(&cnt_q)) ? cnt_q + CNTW'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= '0;
      ov_q    <= 1'b0;
      pkt_q   <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      pkt_q   <= pkt_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign all_done   = (state_q == DONE);
  assign start      = {N{busy}};
  assign in_ready   = load ? gnt : '0;
  assign out_valid  = ov_q;
  assign out_packet = pkt_q;
  assign out_src    = src_q;
  assign pkt_count  = cnt_q;
endmodule

// File: tb/tb_stim_sched.sv
// tb_stim_sched: directed scoreboard bench for stim_sched (N=4, DW=64).
module tb_stim_sched;
  logic         clk, reset, go, out_valid, out_ready, busy, all_done;
  logic [3:0]   start, in_valid, in_done, in_ready;
  logic [255:0] in_packet;
  logic [63:0]  out_packet;
  logic [1:0]   out_src;
  logic [31:0]  pkt_count;

  typedef struct {logic [1:0] src; logic [63:0] pkt;} exp_t;
  exp_t sb[$];
  int   total = 0, passed = 0;

  stim_sched dut (
    .clk(clk), .reset(reset), .go(go), .start(start), .in_valid(in_valid),
    .in_packet(in_packet), .in_done(in_done), .in_ready(in_ready),
    .out_valid(out_valid), .out_packet(out_packet), .out_src(out_src),
    .out_ready(out_ready), .busy(busy), .all_done(all_done), .pkt_count(pkt_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int s);
    exp_t e;
    e.src = 2'(s);
    e.pkt = 64'hA0 + 64'(s);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_xfer", {62'd0, out_src}, 64'hFFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_src", {62'd0, out_src}, {62'd0, e.src});
        chk("xfer_pkt", out_packet, e.pkt);
      end
    end
  end

  initial begin
    reset = 1; go = 0; in_valid = 0; in_done = 0; out_ready = 0;
    in_packet = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_in_ready", in_ready, 0);
    go = 1;
    tick();
    chk("go_start", start, 4'hF);
    chk("go_busy", busy, 1);
`ifdef STIM_SCHED_STRICT_EN
    push(0); push(0); push(0); push(1);
    in_valid = 4'hF; out_ready = 1;
    repeat (3) tick();
    in_valid = 4'b1110;
    tick();
    in_valid = 0;
    repeat (2) tick();
    chk("strict_pkt_count", pkt_count, 4);
`else
    push(0); push(1); push(2); push(3); push(0);
    in_valid = 4'hF; out_ready = 1;
    repeat (5) tick();
    in_valid = 0;
    tick();
    chk("rr_pkt_count", pkt_count, 5);
    chk("rr_slot_empty", out_valid, 0);
    push(1); push(2);
    out_ready = 0; in_valid = 4'hF;
    tick();
    chk("bp_src", out_src, 1);
    repeat (3) begin
      chk("bp_pkt_stable", out_packet, 64'hA1);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1;
    #1;
    chk("bp_release_grant", in_ready, 4'b0100);
    tick();
    in_valid = 0;
    tick();
    chk("bp_pkt_count", pkt_count, 7);
    chk("bp_slot_empty", out_valid, 0);
    push(2);
    in_valid = 4'b0100; in_done = 4'b0100;
    tick();
    in_valid = 4'hF; in_done = 0;
    push(3); push(0); push(1); push(3);
    repeat (4) begin
      #1;
      chk("done_no_gnt2", in_ready[2], 0);
      tick();
    end
    out_ready = 0; in_valid = 0; in_done = 4'b1011;
    tick();
    chk("drain_busy", busy, 1);
    chk("drain_slot_full", out_valid, 1);
    chk("drain_all_done", all_done, 0);
    in_done = 0;
    tick();
    chk("drain_stall_all_done", all_done, 0);
    out_ready = 1;
    tick();
    chk("done_all_done", all_done, 1);
    chk("done_busy", busy, 0);
    chk("done_pkt_count", pkt_count, 12);
    go = 0;
    tick();
    chk("idle_all_done", all_done, 0);
    push(0);
    go = 1;
    tick();
    chk("run_cnt_cleared", pkt_count, 0);
    in_valid = 4'hF;
    tick();
    tick();
    out_ready = 0; in_valid = 0;
    chk("mid_pkt_count", pkt_count, 1);
    chk("mid_slot_full", out_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_start", start, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_pkt_count", pkt_count, 0);
`endif
    chk("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stim_sched.md
# stim_sched

Stimulus scheduler for the DV stimulus library.
- Sequences a bench run: drives the start strobe of N stimulus generators and collects their done flags.
- Merges their valid/packet streams onto one DUT port through a registered, round-robin arbitrated output slot.
- Sits between the stimulus instances and the DUT input; reports a packet count and end-of-run.

## Interface
Parameters:
- N, 4, number of stimulus requesters (N ≥ 1).
- DW, 64, packet width.
- SW, derived = (N>1) ? $clog2(N) : 1, source-id width.
- CNTW, 32, packet counter width.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- go  in  1  run request, level.
- start  out  N  per-requester start, to stimulus ext_start.
- in_valid  in  N  requester packet valid.
- in_packet  in  N*DW  requester packets; requester i uses bits [i*DW +: DW].
- in_done  in  N  requester finished, level or pulse.
- in_ready  out  N  one-hot grant; packet i is accepted when in_valid[i] & in_ready[i].
- out_valid  out  1  output slot full.
- out_packet  out  DW  slot packet.
- out_src  out  SW  index of the requester that supplied the slot packet.
- out_ready  in  1  DUT accepts the slot.
- busy  out  1  state is RUN or DRAIN.
- all_done  out  1  state is DONE.
- pkt_count  out  CNTW  packets delivered to the DUT in this run, saturating.

## Operation
- State machine IDLE → RUN → DRAIN → DONE → IDLE.
  - IDLE → RUN when go = 1. Entering RUN clears done_seen[N-1:0] and pkt_count.
  - RUN → DRAIN when (done_seen | in_done) is all ones. Arbitration still takes place in that cycle.
  - DRAIN → DONE when out_valid = 0, or when out_valid & out_ready.
  - DONE → IDLE when go = 0. go is ignored in RUN and DRAIN.
- start = {N{busy}}: all bits high in RUN and DRAIN.
- done_seen[i] is sticky. It is set in RUN when in_done[i] = 1.
- Eligible requester: in_valid[i] & ~done_seen[i].
  - A packet arriving in the same cycle as its in_done is still eligible and is accepted if granted.
- Load condition: state = RUN & (~out_valid | out_ready) & any eligible requester.
  - in_ready is one-hot to the winner when the load condition holds; otherwise all zeros.
- Round-robin: the search starts at pointer ptr and wraps modulo N. After a grant to i, ptr ← (i+1) mod N. ptr is unchanged when there is no grant.
- Slot behaviour:
  - On load: out_packet and out_src are captured and out_valid = 1.
  - On out_ready with no load: out_valid = 0.
  - out_packet and out_src hold stable while out_valid & ~out_ready.
- pkt_count increments on out_valid & out_ready and saturates at all ones.
- Requesters must not derive in_valid combinationally from in_ready. in_ready depends combinationally on in_valid and out_ready.

## Timing
- Reset values: state IDLE, start 0, in_ready 0, out_valid 0, out_packet 0, out_src 0, busy 0, all_done 0, pkt_count 0, ptr 0, done_seen 0.
- Reset mid-run takes effect at the next edge. start drops that same edge and the slot contents are discarded.
- go sampled high at edge k: start = 1 and busy = 1 after edge k.
- Latency: a packet accepted at edge k gives out_valid = 1 after edge k.
- Throughput: 1 packet/cycle with out_ready held high.
- With all requesters valid and out_ready high, grants rotate 0,1,…,N-1,0.
- all_done rises one cycle after the last slot transfer, or one cycle after the RUN → DRAIN edge if the slot is empty.
- N = 1: ptr is constant 0 and out_src = 0.

## Configuration
- STIM_SCHED_STRICT_EN defined: fixed priority. The lowest eligible index wins and ptr is not implemented.
- Not defined: round-robin as specified above.
- Both builds have identical ports and handshake timing.

## Structure
- Package stim_sched_pkg holds:
  - state encoding localparams: IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, DONE = 2'b11;
  - the SW derivation function.
- Sub-module stim_rr_arb (N-way pick):
  - inputs: eligible vector, advance strobe;
  - outputs: one-hot grant, binary index;
  - owns ptr;
  - STIM_SCHED_STRICT_EN is honoured inside it.
- Top level holds the FSM, done_seen, output slot and pkt_count.

## Test plan
- Reset and idle, N=4: after reset, all outputs 0. Raise go → start = 4'b1111 and busy = 1 next cycle.
- Round-robin: all four valid, each with constant packet 0xA0+i, out_ready = 1. Expect out_src sequence 0,1,2,3,0 on consecutive cycles; pkt_count = 5 after 5 transfers.
- Backpressure: hold out_ready = 0 for 3 cycles while out_valid = 1 → out_packet stable and in_ready = 0. Release → slot drains and the next grant occurs in the same cycle.
- Done handling: in_done[2] pulses with in_valid[2] = 1 → that packet is delivered and requester 2 is never granted again. When all done bits are set with a full, stalled slot → DRAIN until out_ready; all_done follows one cycle after the transfer. Drop go → IDLE.
- Reset mid-run: assert reset in RUN with out_valid = 1 → next cycle state IDLE, out_valid = 0, start = 0, pkt_count = 0.
- STIM_SCHED_STRICT_EN build, all four valid: out_src = 0 every cycle. Drop in_valid[0] → out_src = 1.
